// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the Julia write controller and the read master.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fb_state_t;

    localparam int PIX_W = 32;
    localparam int IDX_W = 20;

    localparam logic [31:0] DEF_FB_BASE = 32'h0000_0000;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on pop_data whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Head is forced to zero while empty so the output never shows stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fb_reader.sv
// Frame-buffer read master: fetches a frame with credit-limited pipelined reads
// and streams the returned pixels out in raster order.
module fb_reader
    import fb_pkg::*;
#(
    parameter logic [31:0] FB_BASE    = DEF_FB_BASE,
    parameter int          H_RES      = DEF_H_RES,
    parameter int          V_RES      = DEF_V_RES,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [31:0]      read_address,
    output logic             read,
    input  logic             wait_request,
    input  logic [PIX_W-1:0] read_data,
    input  logic             read_data_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(H_RES * V_RES - 1);
    localparam logic [CW:0]      CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    fb_state_t        state;
    fb_state_t        state_next;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] req_idx_next;
    logic [IDX_W-1:0] pop_idx;
    logic [IDX_W-1:0] pop_idx_next;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    outstanding_next;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    count_next;
    logic             fifo_empty;
    logic             credit_ok;
    logic             read_next;
    logic [31:0]      address_next;
    logic             frame_done_next;
    logic             accept;
    logic             push;
    logic             pop;

    assign accept    = read && !wait_request;
    // Responses with nothing outstanding are strays (e.g. left over from before a reset).
    assign push      = read_data_valid && (outstanding != '0);
    assign pix_valid = !fifo_empty;
    assign pop       = pix_valid && pix_ready;

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (read_data),
        .pop       (pop),
        .pop_data  (pix_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next      = state;
        req_idx_next    = req_idx;
        pop_idx_next    = pop_idx;
        read_next       = read;
        address_next    = read_address;
        frame_done_next = 1'b0;

        outstanding_next = outstanding;
        if (accept && !push)      outstanding_next = outstanding + 1'b1;
        else if (!accept && push) outstanding_next = outstanding - 1'b1;

        count_next = fifo_count;
        if (push && !pop)      count_next = fifo_count + 1'b1;
        else if (!push && pop) count_next = fifo_count - 1'b1;

        // read is registered, so credit is judged on the occupancy it will see next cycle.
        credit_ok = (({1'b0, count_next} + {1'b0, outstanding_next}) < CREDIT_MAX);

        if (state != IDLE && pop) pop_idx_next = pop_idx + 1'b1;

        unique case (state)
            IDLE: begin
                read_next    = 1'b0;
                address_next = FB_BASE;
                if (start) begin
                    state_next   = FETCH;
                    req_idx_next = '0;
                    pop_idx_next = '0;
                    read_next    = credit_ok;
                end
            end
            FETCH: begin
                if (accept) begin
                    req_idx_next = req_idx + 1'b1;
                    address_next = FB_BASE + 32'({req_idx_next, 2'b00});
                    if (req_idx == LAST_IDX) begin
                        state_next = DRAIN;
                        read_next  = 1'b0;
                    end else begin
                        read_next = credit_ok;
                    end
                end else if (!read) begin
                    read_next = credit_ok;
                end
            end
            DRAIN: begin
                read_next = 1'b0;
                if (pop && pop_idx == LAST_IDX) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_idx      <= '0;
            pop_idx      <= '0;
            outstanding  <= '0;
            read         <= 1'b0;
            read_address <= FB_BASE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_next;
            req_idx      <= req_idx_next;
            pop_idx      <= pop_idx_next;
            outstanding  <= outstanding_next;
            read         <= read_next;
            read_address <= address_next;
            busy         <= (state_next != IDLE);
            frame_done   <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader on a 4x2 frame at 0x1000 with a 4-entry return buffer.
module tb_fb_reader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int NPIX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] read_address;
    logic        read;
    logic        wait_request = 1'b0;
    logic [31:0] read_data = '0;
    logic        read_data_valid = 1'b0;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        busy;
    logic        frame_done;

    fb_reader #(
        .FB_BASE    (BASE),
        .H_RES      (4),
        .V_RES      (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .read_address    (read_address),
        .read            (read),
        .wait_request    (wait_request),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model and observation state, updated on the falling edge.
    int          cyc = 0;
    logic        p0_v = 1'b0, p1_v = 1'b0;
    logic [31:0] p0_d = '0, p1_d = '0;
    logic        accepted;
    logic [31:0] stall_addr = '0;
    int          stall_left = 0;
    int          stall_seen = 0;
    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    logic [31:0] pop_q[$];
    int          acc_count = 0;
    int          pop_count = 0;
    int          max_inflight = 0;
    int          fd_count = 0;
    int          fd_cyc = 0;
    int          last_pop_cyc = 0;
    logic        busy_at_fd = 1'b0;
    logic        busy_before_fd = 1'b0;
    logic        prev_busy = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (stall_left > 0 && read && read_address == stall_addr) begin
            wait_request = 1'b1;
            stall_left--;
            stall_seen++;
        end else begin
            wait_request = 1'b0;
        end
        accepted        = read && !wait_request;
        read_data_valid = p1_v;
        read_data       = p1_d;
        p1_v            = p0_v;
        p1_d            = p0_d;
        p0_v            = accepted;
        p0_d            = read_address >> 2;
        if (accepted) begin
            acc_q.push_back(read_address);
            acc_cyc.push_back(cyc);
            acc_count++;
        end
        if (!rst && pix_valid && pix_ready) begin
            pop_q.push_back(pix_data);
            last_pop_cyc = cyc;
            pop_count++;
        end
        if (acc_count - pop_count > max_inflight) max_inflight = acc_count - pop_count;
        if (frame_done) begin
            fd_count++;
            fd_cyc         = cyc;
            busy_at_fd     = busy;
            busy_before_fd = prev_busy;
        end
        prev_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        acc_q.delete();
        acc_cyc.delete();
        pop_q.delete();
        acc_count    = 0;
        pop_count    = 0;
        max_inflight = 0;
        fd_count     = 0;
    endtask

    task automatic do_start();
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 300; i++) begin
            if (fd_count != 0) break;
            step(1);
        end
        step(2);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_n_req"}, acc_q.size(), NPIX);
        for (int i = 0; i < NPIX; i++)
            if (i < acc_q.size()) chk({tag, "_addr"}, acc_q[i], BASE + 32'(4 * i));
        chk({tag, "_n_pix"}, pop_q.size(), NPIX);
        for (int i = 0; i < NPIX; i++)
            if (i < pop_q.size()) chk({tag, "_pix"}, pop_q[i], 32'h400 + 32'(i));
        chk({tag, "_done_pulses"}, fd_count, 1);
        chk({tag, "_busy_at_done"}, busy_at_fd, 1'b0);
        chk({tag, "_busy_before_done"}, busy_before_fd, 1'b1);
        chk({tag, "_done_after_last_pop"}, fd_cyc, last_pop_cyc + 1);
    endtask

    initial begin
        // Reset values
        #2 rst = 1'b1;
        step(3);
        chk("rst_read", read, 1'b0);
        chk("rst_addr", read_address, BASE);
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_data", pix_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        step(2);

        // Ideal memory, full-rate frame
        clear_obs();
        do_start();
        chk("start_read", read, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("start_addr", read_address, BASE);
        wait_frame();
        check_frame("ideal");
        for (int i = 1; i < NPIX; i++)
            if (i < acc_cyc.size()) chk("ideal_back_to_back", acc_cyc[i], acc_cyc[0] + i);
        if (acc_cyc.size() > 0) chk("ideal_first_pix_latency", last_pop_cyc - NPIX + 1, acc_cyc[0] + 3);
        step(3);
        chk("idle_read", read, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // Five-cycle stall on request 3
        clear_obs();
        stall_addr = BASE + 32'hC;
        stall_left = 5;
        stall_seen = 0;
        do_start();
        wait_frame();
        check_frame("stall");
        chk("stall_cycles", stall_seen, 5);
        if (acc_cyc.size() > 3) chk("stall_gap", acc_cyc[3] - acc_cyc[2], 6);

        // Back-pressure against the 4-entry credit limit
        clear_obs();
        pix_ready = 1'b0;
        do_start();
        step(15);
        chk("bp_accepts", acc_count, 4);
        chk("bp_read_low", read, 1'b0);
        chk("bp_pix_valid", pix_valid, 1'b1);
        chk("bp_head", pix_data, 32'h400);
        pix_ready = 1'b1;
        wait_frame();
        check_frame("bp");
        chk("bp_max_inflight", max_inflight, 4);

        // start pulsed mid-frame is ignored
        clear_obs();
        do_start();
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_frame();
        check_frame("restart_busy");
        step(4);
        chk("restart_busy_idle", busy, 1'b0);
        chk("restart_busy_no_extra", acc_count, NPIX);

        // Reset mid-frame with two responses still in flight, then a fresh frame
        clear_obs();
        do_start();
        for (int i = 0; i < 20; i++) begin
            if (acc_count >= 3) break;
            step(1);
        end
        chk("midrst_accepts", acc_count, 3);
        rst = 1'b1;
        #1;
        chk("midrst_read", read, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pix_valid", pix_valid, 1'b0);
        step(1);
        rst = 1'b0;
        step(4);
        chk("stale_dropped", pix_valid, 1'b0);
        chk("stale_idle", busy, 1'b0);
        clear_obs();
        do_start();
        chk("new_first_addr", read_address, BASE);
        wait_frame();
        check_frame("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
